rca_word_seq_ctrl: RTL and testbench



---
 rtl/rca_word_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_rca_word_seq_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rca_word_seq_ctrl.sv
// rca_word_seq_ctrl
//   Multi-precision adder sequencer. One WORD_W-bit ripple-carry slice is
//   time-shared across NUM_WORDS words. Words are processed least-significant
//   first, one per cycle, and the inter-word carry is held in a register.
//
//   Build option: define RCA_WORD_SEQ_SUB_EN to add the in_sub port, which
//   selects subtraction (a - b). out_cout=1 then means "no borrow".
//
// Ports
//   clk, rst             clock (rising edge) and async active-high reset
//   in_valid/in_ready    operand handshake; in_ready is high only in IDLE
//   in_a, in_b, in_cin   TOT_W-bit operands and the carry into word 0
//   in_sub               (RCA_WORD_SEQ_SUB_EN only) 1 = subtract
//   out_valid/out_ready  result handshake; out_valid is high only in DONE
//   out_sum, out_cout    TOT_W-bit sum and the carry out of the top word
//   busy                 high in RUN or DONE
module rca_word_seq_ctrl #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W*NUM_WORDS-1:0] in_a,
    input  logic [WORD_W*NUM_WORDS-1:0] in_b,
    input  logic                        in_cin,
`ifdef RCA_WORD_SEQ_SUB_EN
    input  logic                        in_sub,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W*NUM_WORDS-1:0] out_sum,
    output logic                        out_cout,
    output logic                        busy
);
    localparam int TOT_W = WORD_W * NUM_WORDS;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [TOT_W-1:0]   a_q, a_d;
    logic [TOT_W-1:0]   b_q, b_d;
    logic [TOT_W-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic [WORD_W:0]    slice;   // {carry_out, sum_word} of the shared slice
    int                 base;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        base  = WORD_W * int'(idx_q);
        slice = {1'b0, a_q[base +: WORD_W]} + {1'b0, b_q[base +: WORD_W]}
              + {{WORD_W{1'b0}}, carry_q};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
`ifdef RCA_WORD_SEQ_SUB_EN
                    // a - b == a + ~b + 1; inverting B once at capture keeps
                    // the per-word datapath identical to the add case.
                    if (in_sub) begin
                        b_d     = ~in_b;
                        carry_d = 1'b1;
                    end
`endif
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[base +: WORD_W] = slice[WORD_W-1:0];
                carry_d               = slice[WORD_W];
                if (idx_q == LAST_IDX) begin
                    // Index parks at the last word; it is cleared on accept.
                    cout_d  = slice[WORD_W];
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_rca_word_seq_ctrl.sv
// Directed bench for rca_word_seq_ctrl (default WORD_W=32, NUM_WORDS=4).
// Inputs are driven and outputs sampled on the falling edge.
module tb_rca_word_seq_ctrl;
    localparam int W = 32;
    localparam int N = 4;
    localparam int T = W * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [T-1:0] in_a;
    logic [T-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [T-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    rca_word_seq_ctrl #(.WORD_W(W), .NUM_WORDS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef RCA_WORD_SEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [T:0] got, input logic [T:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one operation with out_ready already high and check the whole
    // timeline: accept, N RUN cycles, DONE, then return to IDLE.
    task automatic run_op(input string tag, input logic [T-1:0] a, input logic [T-1:0] b,
                          input logic cin, input logic sub, input logic [T:0] exp);
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        chk({tag, " ready_before"}, in_ready, 1'b1);
        @(negedge clk);                 // accepted at the edge just passed
        in_valid = 1'b0;
        chk({tag, " busy_run"}, busy, 1'b1);
        chk({tag, " ready_run"}, in_ready, 1'b0);
        repeat (N - 1) @(negedge clk);
        chk({tag, " valid_early"}, out_valid, 1'b0);
        @(negedge clk);                 // N edges after accept
        chk({tag, " valid"}, out_valid, 1'b1);
        chk({tag, " result"}, {out_cout, out_sum}, exp);
        @(negedge clk);                 // handshake taken
        chk({tag, " valid_drop"}, out_valid, 1'b0);
        chk({tag, " ready_back"}, in_ready, 1'b1);
        chk({tag, " result_kept"}, {out_cout, out_sum}, exp);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        in_sub = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst in_ready", in_ready, 1'b1);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst out_sum", out_sum, '0);
        chk("rst out_cout", out_cout, 1'b0);
        chk("rst busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_op("zero_cin", '0, '0, 1'b1, 1'b0, {1'b0, 128'h1});
        run_op("ripple_all", {T{1'b1}}, '0, 1'b1, 1'b0, {1'b1, 128'h0});
        run_op("ripple_3", 128'h00000001_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 1'b0,
               {1'b0, 128'h00000002_00000000_00000000_00000000});
        run_op("top_cout", 128'h80000000_00000000_00000000_00000000,
               128'h80000000_00000000_00000000_00000000, 1'b0, 1'b0, {1'b1, 128'h0});
        run_op("mixed", 128'h12345678_9ABCDEF0_FFFFFFFF_00000001,
               128'h11111111_11111111_00000001_FFFFFFFF, 1'b1, 1'b0,
               {1'b0, 128'h23456789_ABCDF002_00000001_00000001});

        // Backpressure: consumer stalls while the producer holds a new request.
        out_ready = 1'b0;
        @(negedge clk);
        in_a = 128'd3; in_b = 128'd4; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_a = 128'd100; in_b = 128'd200; in_cin = 1'b1;   // held second request
        repeat (N) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("bp valid", out_valid, 1'b1);
            chk("bp result", {out_cout, out_sum}, {1'b0, 128'd7});
            chk("bp in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);                 // handshake; IDLE with in_valid held
        chk("bp drop", out_valid, 1'b0);
        chk("bp ready", in_ready, 1'b1);
        @(negedge clk);                 // second request accepted
        in_valid = 1'b0;
        chk("bp2 busy", busy, 1'b1);
        repeat (N) @(negedge clk);
        chk("bp2 valid", out_valid, 1'b1);
        chk("bp2 result", {out_cout, out_sum}, {1'b0, 128'd301});
        @(negedge clk);

        // Reset during the second RUN cycle aborts the operation.
        in_a = {T{1'b1}}; in_b = {T{1'b1}}; in_cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort sum", out_sum, '0);
        chk("abort cout", out_cout, 1'b0);
        chk("abort valid", out_valid, 1'b0);
        chk("abort ready", in_ready, 1'b1);
        chk("abort busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_abort", 128'h5, 128'hA, 1'b0, 1'b0, {1'b0, 128'hF});

`ifdef RCA_WORD_SEQ_SUB_EN
        run_op("sub_5_7", 128'd5, 128'd7, 1'b0, 1'b1,
               {1'b0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE});
        run_op("sub_7_5", 128'd7, 128'd5, 1'b0, 1'b1, {1'b1, 128'h2});
        run_op("sub_cin_ign", 128'd7, 128'd5, 1'b1, 1'b1, {1'b1, 128'h2});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
